// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer multi-buffer manager.
// The FB_DROP_COUNT_EN build option is handled in fb_multibuffer_manager.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWAP  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } fb_state_e;

  function automatic int fb_words(input int w, input int h, input int ppw);
    return (w * h) / ppw;
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser plus a registered rising-edge strobe for slow
// level pulses entering the system clock domain.
module pulse_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic strobe
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q, edge_d;
  logic strobe_q, strobe_d;

  always_comb begin
    sync1_d  = async_in;
    sync2_d  = sync1_q;
    edge_d   = sync2_q;
    strobe_d = sync2_q & ~edge_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      edge_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      edge_q   <= edge_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/fb_multibuffer_manager.sv
// Framebuffer rotation and clear controller: swaps buffers on a frame event once a frame is drawn,
// then clears the new draw buffer. Define FB_DROP_COUNT_EN to add the frames_dropped counter.
module fb_multibuffer_manager
  import fb_pkg::*;
#(
  parameter  int SCREEN_WIDTH    = 640,
  parameter  int SCREEN_HEIGHT   = 480,
  parameter  int PIXEL_WIDTH     = 1,
  parameter  int PIXELS_PER_WORD = 4,
  parameter  int NUM_BUFFERS     = 2,
  localparam int WORDS           = fb_words(SCREEN_WIDTH, SCREEN_HEIGHT, PIXELS_PER_WORD),
  localparam int ADDR_WIDTH      = $clog2(WORDS),
  localparam int SEL_WIDTH       = $clog2(NUM_BUFFERS)
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   frame_pulse,
  input  logic                                   draw_done,
  input  logic [PIXEL_WIDTH-1:0]                 clear_color,
  input  logic                                   pixel_wr_ready,
  output logic [ADDR_WIDTH-1:0]                  pixel_addr,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] pixel_data,
  output logic                                   pixel_wr_en,
  output logic                                   clearing_framebuffer,
  output logic [SEL_WIDTH-1:0]                   draw_sel,
  output logic [SEL_WIDTH-1:0]                   display_sel,
  output logic                                   draw_ready,
  output logic                                   swap_done
`ifdef FB_DROP_COUNT_EN
  ,
  output logic [15:0]                            frames_dropped
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
  localparam logic [SEL_WIDTH-1:0]  LAST_SEL  = SEL_WIDTH'(NUM_BUFFERS - 1);

  fb_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [PIXEL_WIDTH-1:0]   color_q, color_d;
  logic [SEL_WIDTH-1:0]     draw_sel_q, draw_sel_d;
  logic [SEL_WIDTH-1:0]     display_sel_q, display_sel_d;
  logic                     wr_en_q, wr_en_d;
  logic                     clearing_q, clearing_d;
  logic                     swap_done_q, swap_done_d;
  logic                     draw_ready_q, draw_ready_d;
  logic                     pending_q, pending_d;
  logic                     frame_evt;

  pulse_sync_edge u_frame_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (frame_pulse),
    .strobe   (frame_evt)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    color_d       = color_q;
    draw_sel_d    = draw_sel_q;
    display_sel_d = display_sel_q;
    wr_en_d       = wr_en_q;
    clearing_d    = clearing_q;
    swap_done_d   = 1'b0;
    pending_d     = pending_q;

    case (state_q)
      IDLE: begin
        if (frame_evt && pending_q) begin
          state_d       = SWAP;
          display_sel_d = draw_sel_q;
          draw_sel_d    = (draw_sel_q == LAST_SEL) ? '0 : draw_sel_q + SEL_WIDTH'(1);
          addr_d        = '0;
          color_d       = clear_color;
          clearing_d    = 1'b1;
        end
      end
      SWAP: begin
        state_d = CLEAR;
        wr_en_d = 1'b1;
      end
      CLEAR: begin
        // A stalled word keeps its address; the last accepted word ends the clear without wrapping.
        if (wr_en_q && pixel_wr_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d     = DONE;
            wr_en_d     = 1'b0;
            clearing_d  = 1'b0;
            swap_done_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (draw_done && draw_ready_q) pending_d = 1'b1;
    if (state_d == SWAP) pending_d = 1'b0;
    draw_ready_d = (state_d == IDLE) && !pending_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      color_q       <= '0;
      draw_sel_q    <= SEL_WIDTH'(1);
      display_sel_q <= '0;
      wr_en_q       <= 1'b0;
      clearing_q    <= 1'b0;
      swap_done_q   <= 1'b0;
      draw_ready_q  <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      color_q       <= color_d;
      draw_sel_q    <= draw_sel_d;
      display_sel_q <= display_sel_d;
      wr_en_q       <= wr_en_d;
      clearing_q    <= clearing_d;
      swap_done_q   <= swap_done_d;
      draw_ready_q  <= draw_ready_d;
      pending_q     <= pending_d;
    end
  end

`ifdef FB_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Any frame event that does not start a swap is a repeated frame.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (frame_evt && !((state_q == IDLE) && pending_q) && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) drop_cnt_q <= 16'd0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign frames_dropped = drop_cnt_q;
`endif

  assign pixel_addr           = addr_q;
  assign pixel_data           = {PIXELS_PER_WORD{color_q}};
  assign pixel_wr_en          = wr_en_q;
  assign clearing_framebuffer = clearing_q;
  assign draw_sel             = draw_sel_q;
  assign display_sel          = display_sel_q;
  assign draw_ready           = draw_ready_q;
  assign swap_done            = swap_done_q;

endmodule
